// File: rtl/lbist_sequencer.sv
// ----------------------------------------------------------------------------
// lbist_sequencer
//   Logic-BIST run sequencer. One request on bist_start produces a fixed,
//   cycle-exact schedule:
//     SEED (1) -> { SHIFT (CHAIN_LEN) -> CAPTURE (1) } x N_PATTERNS
//              -> UNLOAD (CHAIN_LEN) -> COMPARE (1) -> DONE
//   The final MISR signature is compared against GOLDEN in COMPARE and
//   the result is held on pass_fail until the next run is seeded.
//
// Ports
//   CLK          system clock, rising edge
//   RST          asynchronous, active-high reset
//   bist_start   level run request, sampled only in IDLE and DONE
//   sig_in       current MISR signature
//   seed_load    one-cycle pulse, LFSRs load their seed
//   misr_clr     one-cycle pulse, MISR clears to 0
//   misr_en      MISR compacts this cycle
//   scan_en      1 = shift, 0 = functional/capture (also LFSR input mux select)
//   bist_running high from SEED through COMPARE inclusive
//   bist_end     high while in DONE
//   pass_fail    1 = signature matched GOLDEN, valid while bist_end = 1
//   pattern_cnt  patterns captured so far in the current run
// ----------------------------------------------------------------------------
module lbist_sequencer #(
   parameter int               CHAIN_LEN  = 21,
   parameter int               N_PATTERNS = 85,
   parameter int               SIG_W      = 21,
   parameter logic [SIG_W-1:0] GOLDEN     = {SIG_W{1'b0}},
   parameter int               CNT_W      = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             bist_start,
   input  logic [SIG_W-1:0] sig_in,
   output logic             seed_load,
   output logic             misr_clr,
   output logic             misr_en,
   output logic             scan_en,
   output logic             bist_running,
   output logic             bist_end,
   output logic             pass_fail,
   output logic [CNT_W-1:0] pattern_cnt
);

   // Both counters must reach their terminal values without wrapping:
   // the shift counter tops out at CHAIN_LEN-1, pattern_cnt at N_PATTERNS.
   if (CHAIN_LEN < 1 || N_PATTERNS < 1 ||
       CHAIN_LEN >= (2 ** CNT_W) || N_PATTERNS >= (2 ** CNT_W)) begin : g_bad_params
      $error("lbist_sequencer: CHAIN_LEN/N_PATTERNS must be >= 1 and fit in CNT_W bits");
   end

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SEED    = 3'd1;
   localparam logic [2:0] S_SHIFT   = 3'd2;
   localparam logic [2:0] S_CAPTURE = 3'd3;
   localparam logic [2:0] S_UNLOAD  = 3'd4;
   localparam logic [2:0] S_COMPARE = 3'd5;
   localparam logic [2:0] S_DONE    = 3'd6;

   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);
   localparam logic [CNT_W-1:0] LAST_PAT   = CNT_W'(N_PATTERNS - 1);

   logic [2:0]       state_q,       state_d;
   logic [CNT_W-1:0] shift_cnt_q,   shift_cnt_d;
   logic [CNT_W-1:0] pattern_cnt_q, pattern_cnt_d;
   logic             pass_fail_q,   pass_fail_d;

   logic seed_load_q,    seed_load_d;
   logic misr_clr_q,     misr_clr_d;
   logic misr_en_q,      misr_en_d;
   logic scan_en_q,      scan_en_d;
   logic bist_running_q, bist_running_d;
   logic bist_end_q,     bist_end_d;

   // Next-state and counter/result update logic.
   always_comb begin
      state_d       = state_q;
      shift_cnt_d   = shift_cnt_q;
      pattern_cnt_d = pattern_cnt_q;
      pass_fail_d   = pass_fail_q;
      case (state_q)
         S_IDLE: begin
            if (bist_start) begin
               // Clear on entry so SEED already shows a fresh pattern_cnt/pass_fail.
               state_d       = S_SEED;
               shift_cnt_d   = CNT_ZERO;
               pattern_cnt_d = CNT_ZERO;
               pass_fail_d   = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SEED: begin
            state_d       = S_SHIFT;
            shift_cnt_d   = CNT_ZERO;
            pattern_cnt_d = CNT_ZERO;
            pass_fail_d   = 1'b0;
         end
         S_SHIFT, S_UNLOAD: begin
            // Terminal count also works for CHAIN_LEN = 1 (LAST_SHIFT = 0).
            if (shift_cnt_q == LAST_SHIFT) begin
               shift_cnt_d = CNT_ZERO;
               if (state_q == S_SHIFT) begin
                  state_d = S_CAPTURE;
               end else begin
                  state_d = S_COMPARE;
               end
            end else begin
               shift_cnt_d = shift_cnt_q + CNT_ONE;
            end
         end
         S_CAPTURE: begin
            pattern_cnt_d = pattern_cnt_q + CNT_ONE;
            if (pattern_cnt_q == LAST_PAT) begin
               state_d = S_UNLOAD;
            end else begin
               state_d = S_SHIFT;
            end
         end
         S_COMPARE: begin
            pass_fail_d = (sig_in == GOLDEN);
            state_d     = S_DONE;
         end
         S_DONE: begin
            // Leaving DONE needs bist_start low, so a held request never restarts.
            if (!bist_start) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d       = S_IDLE;
            shift_cnt_d   = CNT_ZERO;
            pattern_cnt_d = CNT_ZERO;
            pass_fail_d   = 1'b0;
         end
      endcase
   end

   // Strobe decode from the next state so every strobe leaves a flop.
   always_comb begin
      seed_load_d    = 1'b0;
      misr_clr_d     = 1'b0;
      misr_en_d      = 1'b0;
      scan_en_d      = 1'b0;
      bist_running_d = 1'b0;
      bist_end_d     = 1'b0;
      case (state_d)
         S_IDLE: begin
            bist_running_d = 1'b0;
         end
         S_SEED: begin
            seed_load_d    = 1'b1;
            misr_clr_d     = 1'b1;
            bist_running_d = 1'b1;
         end
         S_SHIFT, S_UNLOAD: begin
            scan_en_d      = 1'b1;
            misr_en_d      = 1'b1;
            bist_running_d = 1'b1;
         end
         S_CAPTURE: begin
            misr_en_d      = 1'b1;
            bist_running_d = 1'b1;
         end
         S_COMPARE: begin
            bist_running_d = 1'b1;
         end
         S_DONE: begin
            bist_end_d = 1'b1;
         end
         default: begin
            bist_running_d = 1'b0;
         end
      endcase
   end

   // State, counters, result and registered strobes.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q        <= S_IDLE;
         shift_cnt_q    <= CNT_ZERO;
         pattern_cnt_q  <= CNT_ZERO;
         pass_fail_q    <= 1'b0;
         seed_load_q    <= 1'b0;
         misr_clr_q     <= 1'b0;
         misr_en_q      <= 1'b0;
         scan_en_q      <= 1'b0;
         bist_running_q <= 1'b0;
         bist_end_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         shift_cnt_q    <= shift_cnt_d;
         pattern_cnt_q  <= pattern_cnt_d;
         pass_fail_q    <= pass_fail_d;
         seed_load_q    <= seed_load_d;
         misr_clr_q     <= misr_clr_d;
         misr_en_q      <= misr_en_d;
         scan_en_q      <= scan_en_d;
         bist_running_q <= bist_running_d;
         bist_end_q     <= bist_end_d;
      end
   end

   assign seed_load    = seed_load_q;
   assign misr_clr     = misr_clr_q;
   assign misr_en      = misr_en_q;
   assign scan_en      = scan_en_q;
   assign bist_running = bist_running_q;
   assign bist_end     = bist_end_q;
   assign pass_fail    = pass_fail_q;
   assign pattern_cnt  = pattern_cnt_q;

endmodule

// File: tb/tb_lbist_sequencer.sv
module tb_lbist_sequencer;

   // Instance A: CHAIN_LEN=4, N_PATTERNS=3
   localparam int C  = 4;
   localparam int N  = 3;
   localparam int SW = 21;
   localparam logic [SW-1:0] GOLD = 21'h1A5C3;
   localparam int L        = 2 + N * (C + 1) + C;   // sampling edge -> bist_end
   localparam int SCAN_TOT = (N + 1) * C;
   localparam int MISR_TOT = (N + 1) * C + N;

   // Instance B: CHAIN_LEN=1, N_PATTERNS=1
   localparam int CB  = 1;
   localparam int NB  = 1;
   localparam logic [7:0] GOLDB = 8'h5A;

   // Strobe vectors {seed_load, misr_clr, misr_en, scan_en, bist_running, bist_end}
   localparam logic [5:0] P_SEED  = 6'b110010;
   localparam logic [5:0] P_SHIFT = 6'b001110;
   localparam logic [5:0] P_CAPT  = 6'b001010;
   localparam logic [5:0] P_CMP   = 6'b000010;
   localparam logic [5:0] P_DONE  = 6'b000001;

   logic clk = 1'b0;
   logic rst;
   logic a_start, a_seed, a_clr, a_misr, a_scan, a_run, a_end, a_pf;
   logic [SW-1:0] a_sig;
   logic [7:0]    a_pcnt;
   logic b_start, b_seed, b_clr, b_misr, b_scan, b_run, b_end, b_pf;
   logic [7:0]    b_sig;
   logic [3:0]    b_pcnt;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   lbist_sequencer #(.CHAIN_LEN(C), .N_PATTERNS(N), .SIG_W(SW), .GOLDEN(GOLD), .CNT_W(8)) dut_a (
      .CLK(clk), .RST(rst), .bist_start(a_start), .sig_in(a_sig),
      .seed_load(a_seed), .misr_clr(a_clr), .misr_en(a_misr), .scan_en(a_scan),
      .bist_running(a_run), .bist_end(a_end), .pass_fail(a_pf), .pattern_cnt(a_pcnt));

   lbist_sequencer #(.CHAIN_LEN(CB), .N_PATTERNS(NB), .SIG_W(8), .GOLDEN(GOLDB), .CNT_W(4)) dut_b (
      .CLK(clk), .RST(rst), .bist_start(b_start), .sig_in(b_sig),
      .seed_load(b_seed), .misr_clr(b_clr), .misr_en(b_misr), .scan_en(b_scan),
      .bist_running(b_run), .bist_end(b_end), .pass_fail(b_pf), .pattern_cnt(b_pcnt));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [SW-1:0] nz();
      logic [SW-1:0] x;
      x = SW'($urandom);
      if (x == '0) x = 1;
      return x;
   endfunction

   // ---------------- scoreboard A: one entry per expected run ----------------
   typedef struct { int seed_cyc; int end_cyc; logic pass; } run_t;
   run_t sb_a[$];

   bit   in_run = 0;
   int   seed_at, scan_n, misr_n, run_n, burst_len, bursts;
   logic prev_scan = 1'b0;

   always @(negedge clk) begin : mon_a
      run_t r;
      if (rst) begin
         in_run    = 0;
         prev_scan = 1'b0;
      end else begin
         if (a_seed || a_clr) chk("seed_clr_pair", a_clr, a_seed);
         if (a_seed) begin
            chk("seed_while_running", in_run, 0);
            in_run = 1; seed_at = cyc;
            scan_n = 0; misr_n = 0; run_n = 0; burst_len = 0; bursts = 0;
         end
         if (in_run) begin
            if (a_scan) scan_n++;
            if (a_misr) misr_n++;
            if (a_run)  run_n++;
            if (a_scan) burst_len++;
            else if (prev_scan) begin
               chk("scan_burst_len", burst_len, C);
               bursts++;
               burst_len = 0;
            end
            if (cyc == seed_at + 1) begin
               chk("pcnt_cleared", a_pcnt, 0);
               chk("pf_cleared", a_pf, 0);
            end
            if (a_end) begin
               chk("end_vs_running", a_run, 0);
               if (sb_a.size() == 0) begin
                  chk("unexpected_end", sb_a.size(), 1);
               end else begin
                  r = sb_a.pop_front();
                  chk("seed_cycle", seed_at, r.seed_cyc);
                  chk("end_cycle", cyc, r.end_cyc);
                  chk("scan_total", scan_n, SCAN_TOT);
                  chk("misr_total", misr_n, MISR_TOT);
                  chk("running_cycles", run_n, L);
                  chk("scan_bursts", bursts, N + 1);
                  chk("pattern_cnt", a_pcnt, N);
                  chk("pass_fail", a_pf, r.pass);
               end
               in_run = 0;
            end
         end
         prev_scan = a_scan;
      end
   end

   // ---------------- scoreboard B: per-cycle expected strobes ----------------
   typedef struct { int cyc; logic [5:0] strobes; bit tail; } bexp_t;
   bexp_t sb_b[$];

   always @(negedge clk) begin : mon_b
      bexp_t e;
      if (!rst && sb_b.size() > 0 && cyc == sb_b[0].cyc) begin
         e = sb_b.pop_front();
         chk("b_strobes", {b_seed, b_clr, b_misr, b_scan, b_run, b_end}, e.strobes);
         if (e.tail) begin
            chk("b_pattern_cnt", b_pcnt, NB);
            chk("b_pass_fail", b_pf, 1);
         end
      end
   end

   // One run on instance A; drop = release bist_start during the second SHIFT.
   task automatic run_a(input bit drop, input bit pass);
      int   m;
      bit   seen;
      run_t r;
      @(negedge clk);
      m = cyc;
      a_start = 1'b1;
      r.seed_cyc = m + 1; r.end_cyc = m + 1 + L; r.pass = pass;
      sb_a.push_back(r);
      seen = 0;
      for (int k = 0; k < L + 10 && !seen; k++) begin
         @(negedge clk);
         if (drop && cyc == m + 1 + C + 3) a_start = 1'b0;
         // Only the COMPARE cycle sees the chosen signature; everything else is junk.
         if (cyc == m + L) a_sig = pass ? GOLD : (GOLD ^ nz());
         else              a_sig = GOLD ^ nz();
         if (a_end) seen = 1;
      end
      if (!seen) chk("end_timeout", seen, 1);
      if (!drop) begin
         repeat ($urandom_range(2, 6)) begin
            @(negedge clk);
            chk("done_hold", a_end, 1);
            chk("no_reseed", a_seed, 0);
         end
      end
      a_start = 1'b0;
      @(negedge clk);
      chk("idle_after_done", a_end, 0);
      chk("idle_running", a_run, 0);
      chk("pf_retained", a_pf, pass);
      repeat ($urandom_range(1, 3)) @(negedge clk);
   endtask

   initial begin : stim
      int m;
      int pos;
      rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
      a_sig = GOLD ^ 21'h1; b_sig = GOLDB;
      repeat (3) @(negedge clk);
      chk("rst_seed", a_seed, 0);   chk("rst_scan", a_scan, 0);
      chk("rst_running", a_run, 0); chk("rst_end", a_end, 0);
      chk("rst_pf", a_pf, 0);       chk("rst_pcnt", a_pcnt, 0);
      chk("rst_b_end", b_end, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_no_start", a_run, 0);

      // Directed: passing run with bist_start held through DONE.
      run_a(0, 1);

      // Async reset from IDLE clears the retained result and count.
      @(posedge clk); #2 rst = 1'b1; #1;
      chk("rst_clears_pf", a_pf, 0);
      chk("rst_clears_pcnt", a_pcnt, 0);
      @(negedge clk); rst = 1'b0;

      // Async reset in the middle of SHIFT.
      @(negedge clk); a_start = 1'b1;
      repeat (4) @(negedge clk);
      chk("in_shift_before_rst", a_scan, 1);
      @(posedge clk); #2 rst = 1'b1; #1;
      chk("async_seed", a_seed, 0); chk("async_clr", a_clr, 0);
      chk("async_misr", a_misr, 0); chk("async_scan", a_scan, 0);
      chk("async_run", a_run, 0);   chk("async_end", a_end, 0);
      chk("async_pf", a_pf, 0);     chk("async_pcnt", a_pcnt, 0);
      a_start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_idle_run", a_run, 0);
         chk("post_rst_idle_seed", a_seed, 0);
      end

      // Directed: failing signature, then mid-run release of bist_start.
      run_a(0, 0);
      run_a(1, 1);

      // Randomized runs.
      for (int i = 0; i < 8; i++) run_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      // Instance B: CHAIN_LEN=1, N_PATTERNS=1 sequence.
      @(negedge clk);
      m = cyc;
      b_start = 1'b1;
      pos = m + 1;
      sb_b.push_back('{pos, P_SEED, 0}); pos++;
      for (int p = 0; p < NB; p++) begin
         for (int s = 0; s < CB; s++) begin sb_b.push_back('{pos, P_SHIFT, 0}); pos++; end
         sb_b.push_back('{pos, P_CAPT, 0}); pos++;
      end
      for (int s = 0; s < CB; s++) begin sb_b.push_back('{pos, P_SHIFT, 0}); pos++; end
      sb_b.push_back('{pos, P_CMP, 0}); pos++;
      sb_b.push_back('{pos, P_DONE, 1}); pos++;
      repeat (10) @(negedge clk);
      chk("b_done_hold", b_end, 1);
      b_start = 1'b0;
      repeat (2) @(negedge clk);
      chk("b_idle", b_end, 0);

      repeat (3) @(negedge clk);
      chk("sb_a_drained", sb_a.size(), 0);
      chk("sb_b_drained", sb_b.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
